// File: rtl/dqsw_delay_sweep_ctrl_if.sv
// Signal bundle between the DQSW delay-sweep controller and the training IOD / sequencer.
// The controller takes the master modport. Its peers take the slave modport.
interface dqsw_delay_sweep_ctrl_if #(
   parameter int MAX_TAPS = 128
);
   localparam int TW = $clog2(MAX_TAPS);

   // Protocol: TRAIN_START is a one-cycle request with no back-pressure. It is honoured only
   // when the sweep is not busy. LOAD/MOVE/CLEAR_FLAGS are one-cycle registered pulses.
   // TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR and TAP_COUNT are registered levels.
   logic          TRAIN_START;
   logic [1:0]    RX_DATA;
   logic          DELAY_LINE_OUT_OF_RANGE;
   logic          DELAY_LINE_LOAD;
   logic          DELAY_LINE_MOVE;
   logic          DELAY_LINE_DIRECTION;
   logic          EYE_MONITOR_CLEAR_FLAGS;
   logic          TRAIN_BUSY;
   logic          TRAIN_DONE;
   logic          TRAIN_ERR;
   logic [TW-1:0] TAP_COUNT;
   logic [2:0]    DBG_STATE;

   modport master (
      input  TRAIN_START,
      input  RX_DATA,
      input  DELAY_LINE_OUT_OF_RANGE,
      output DELAY_LINE_LOAD,
      output DELAY_LINE_MOVE,
      output DELAY_LINE_DIRECTION,
      output EYE_MONITOR_CLEAR_FLAGS,
      output TRAIN_BUSY,
      output TRAIN_DONE,
      output TRAIN_ERR,
      output TAP_COUNT,
      output DBG_STATE
   );

   modport slave (
      output TRAIN_START,
      output RX_DATA,
      output DELAY_LINE_OUT_OF_RANGE,
      input  DELAY_LINE_LOAD,
      input  DELAY_LINE_MOVE,
      input  DELAY_LINE_DIRECTION,
      input  EYE_MONITOR_CLEAR_FLAGS,
      input  TRAIN_BUSY,
      input  TRAIN_DONE,
      input  TRAIN_ERR,
      input  TAP_COUNT,
      input  DBG_STATE
   );
endinterface

// File: rtl/dqsw_delay_sweep_ctrl.sv
// DQSW delay-line sweep: step the delay one tap at a time until a 0 -> 1 eye edge is found.
// Each tap is a majority vote over SAMPLES RX_DATA==2'b11 samples. A tie votes 0.
module dqsw_delay_sweep_ctrl #(
   parameter int MAX_TAPS      = 128,
   parameter int SETTLE_CYCLES = 8,
   parameter int SAMPLES       = 4
) (
   input  logic                           FAB_CLK,
   input  logic                           RESET,
   dqsw_delay_sweep_ctrl_if.master        sweep_if
);
   localparam int TW = $clog2(MAX_TAPS);
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int NW = $clog2(SAMPLES);
   localparam int OW = $clog2(SAMPLES + 1);

   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [NW-1:0] SAMPLE_LAST = NW'(SAMPLES - 1);
   localparam logic [OW-1:0] ONES_HALF   = OW'(SAMPLES / 2);
   localparam logic [TW-1:0] TAP_LAST    = TW'(MAX_TAPS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SETTLE = 3'd2,
      S_SAMPLE = 3'd3,
      S_EVAL   = 3'd4,
      S_MOVE   = 3'd5,
      S_DONE   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   state_t        r_state;
   logic [SW-1:0] r_settle_cnt;
   logic [NW-1:0] r_sample_cnt;
   logic [OW-1:0] r_ones;
   logic          r_tap_val;
   logic          r_seen_zero;
   logic [TW-1:0] r_tap_count;
   logic          r_load;
   logic          r_move;
   logic          r_dir;
   logic          r_clr;
   logic          r_busy;
   logic          r_done;
   logic          r_err;

   logic          w_hit;
   logic [OW-1:0] w_ones_next;

   assign w_hit       = &sweep_if.RX_DATA;
   assign w_ones_next = r_ones + OW'(w_hit);

   always_ff @(posedge FAB_CLK or posedge RESET) begin
      if (RESET) begin
         r_state      <= S_IDLE;
         r_settle_cnt <= '0;
         r_sample_cnt <= '0;
         r_ones       <= '0;
         r_tap_val    <= 1'b0;
         r_seen_zero  <= 1'b0;
         r_tap_count  <= '0;
         r_load       <= 1'b0;
         r_move       <= 1'b0;
         r_dir        <= 1'b0;
         r_clr        <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_load <= 1'b0;
         r_move <= 1'b0;
         r_clr  <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (sweep_if.TRAIN_START) begin
                  r_state     <= S_LOAD;
                  r_load      <= 1'b1;
                  r_clr       <= 1'b1;
                  r_busy      <= 1'b1;
                  r_dir       <= 1'b1;
                  r_done      <= 1'b0;
                  r_err       <= 1'b0;
                  r_tap_count <= '0;
                  r_seen_zero <= 1'b0;
               end
            end
            S_LOAD: begin
               r_state      <= S_SETTLE;
               r_settle_cnt <= '0;
            end
            S_SETTLE: begin
               if (r_settle_cnt == SETTLE_LAST) begin
                  r_state      <= S_SAMPLE;
                  r_sample_cnt <= '0;
                  r_ones       <= '0;
               end else begin
                  r_settle_cnt <= r_settle_cnt + SW'(1);
               end
            end
            S_SAMPLE: begin
               r_ones <= w_ones_next;
               if (r_sample_cnt == SAMPLE_LAST) begin
                  // The vote includes this last sample, so it uses the next count.
                  r_tap_val <= (w_ones_next > ONES_HALF);
                  r_state   <= S_EVAL;
               end else begin
                  r_sample_cnt <= r_sample_cnt + NW'(1);
               end
            end
            S_EVAL: begin
               if (r_tap_val && r_seen_zero) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  // A leading 1 (already past the edge) keeps sweeping until a 0 is seen.
                  if (!r_tap_val) begin
                     r_seen_zero <= 1'b1;
                  end
                  if (sweep_if.DELAY_LINE_OUT_OF_RANGE || (r_tap_count == TAP_LAST)) begin
                     r_state <= S_ERR;
                     r_busy  <= 1'b0;
                     r_err   <= 1'b1;
                  end else begin
                     r_state     <= S_MOVE;
                     r_move      <= 1'b1;
                     r_tap_count <= r_tap_count + TW'(1);
                  end
               end
            end
            S_MOVE: begin
               r_state      <= S_SETTLE;
               r_settle_cnt <= '0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign sweep_if.DELAY_LINE_LOAD         = r_load;
   assign sweep_if.DELAY_LINE_MOVE         = r_move;
   assign sweep_if.DELAY_LINE_DIRECTION    = r_dir;
   assign sweep_if.EYE_MONITOR_CLEAR_FLAGS = r_clr;
   assign sweep_if.TRAIN_BUSY              = r_busy;
   assign sweep_if.TRAIN_DONE              = r_done;
   assign sweep_if.TRAIN_ERR               = r_err;
   assign sweep_if.TAP_COUNT               = r_tap_count;
   assign sweep_if.DBG_STATE               = r_state;
endmodule

// File: doc/dqsw_delay_sweep_ctrl.md
DQSW_DELAY_SWEEP_CTRL -- requirements
Module: dqsw_delay_sweep_ctrl

Interface
REQ-001 Parameter MAX_TAPS, default 128: number of delay-line taps swept; taps are indexed 0..MAX_TAPS-1.
REQ-002 Parameter SETTLE_CYCLES, default 8: FAB_CLK cycles waited after each load or move before sampling.
REQ-003 Parameter SAMPLES, default 4: RX_DATA samples taken per tap; the value shall be even and at least 2.
REQ-004 Port FAB_CLK, input, width 1: the single clock; all state is in this domain.
REQ-005 Port RESET, input, width 1: asynchronous, active-high reset.
REQ-006 Port TRAIN_START, input, width 1: single-cycle request to begin a sweep.
REQ-007 Port RX_DATA, input, width 2: DQ feedback bits from the DQSW training IOD.
REQ-008 Port DELAY_LINE_OUT_OF_RANGE, input, width 1: delay-line limit flag from the IOD.
REQ-009 Port DELAY_LINE_LOAD, output, width 1: single-cycle pulse that reloads the IOD delay line to its static value.
REQ-010 Port DELAY_LINE_MOVE, output, width 1: single-cycle pulse that steps the delay line by one tap.
REQ-011 Port DELAY_LINE_DIRECTION, output, width 1: step direction, 1 = increment.
REQ-012 Port EYE_MONITOR_CLEAR_FLAGS, output, width 1: single-cycle pulse that clears the IOD eye-monitor flags.
REQ-013 Port TRAIN_BUSY, output, width 1: high while a sweep is in progress.
REQ-014 Port TRAIN_DONE, output, width 1: sweep succeeded; held high until the next TRAIN_START.
REQ-015 Port TRAIN_ERR, output, width 1: sweep failed; held high until the next TRAIN_START.
REQ-016 Port TAP_COUNT, output, width clog2(MAX_TAPS): number of MOVE pulses issued in the current or last sweep.

Function
REQ-017 The FSM shall have the states IDLE, LOAD, SETTLE, SAMPLE, EVAL, MOVE, DONE and ERR; all outputs shall be registered.
REQ-018 In IDLE, DONE or ERR, a TRAIN_START pulse shall enter LOAD on the next edge and clear TRAIN_DONE, TRAIN_ERR, TAP_COUNT and seen_zero.
REQ-019 While in LOAD, SETTLE, SAMPLE, EVAL or MOVE, TRAIN_START shall be ignored.
REQ-020 LOAD shall last 1 cycle and assert DELAY_LINE_LOAD and EYE_MONITOR_CLEAR_FLAGS together; the next state is SETTLE.
REQ-021 SETTLE shall last exactly SETTLE_CYCLES cycles; the next state is SAMPLE.
REQ-022 SAMPLE shall last SAMPLES cycles; a cycle counts as a one when RX_DATA==2'b11 (bitwise AND of both bits).
REQ-023 The tap value shall be 1 only when the ones count is strictly greater than SAMPLES/2; a tie shall evaluate to 0.
REQ-024 EVAL shall last 1 cycle and apply the following priority:
- (a) tap value 1 with seen_zero=1: go to DONE.
- (b) tap value 0: set seen_zero=1.
- (c) then, if DELAY_LINE_OUT_OF_RANGE=1 or TAP_COUNT==MAX_TAPS-1: go to ERR.
- (d) otherwise: go to MOVE.
REQ-025 A tap value of 1 with seen_zero=0 (already past the edge at the start) shall not terminate the sweep; evaluation continues by rule (c)/(d).
REQ-026 MOVE shall last 1 cycle, assert DELAY_LINE_MOVE, and increment TAP_COUNT by 1 (no wrap); the next state is SETTLE.
REQ-027 DELAY_LINE_DIRECTION shall be 1 in every state except IDLE, where it shall be 0.
REQ-028 TRAIN_BUSY shall be high exactly in LOAD, SETTLE, SAMPLE, EVAL and MOVE.
REQ-029 TAP_COUNT shall hold its final value in DONE and in ERR.
REQ-030 TAP_COUNT shall never exceed MAX_TAPS-1, and at most MAX_TAPS-1 MOVE pulses shall occur per sweep.
REQ-031 Latency: LOAD shall be entered 1 cycle after TRAIN_START; each tap after the first shall cost 1+SETTLE_CYCLES+SAMPLES+1 cycles.

Reset
REQ-032 While RESET=1, the FSM shall be held in IDLE and every output shall be 0, taking effect immediately and asynchronously, including mid-sweep.
REQ-033 Internal counters and seen_zero shall reset to 0.
REQ-034 After RESET is released, no pulse shall be issued until a TRAIN_START is received.

Verification (MAX_TAPS=128, SETTLE_CYCLES=8, SAMPLES=4)
REQ-035 RX_DATA=00 for taps 0-9, then 11 from tap 10 -> TRAIN_DONE=1, TAP_COUNT=10, exactly 10 MOVE pulses, 1 LOAD pulse.
REQ-036 RX_DATA=11 for taps 0-2, 00 for taps 3-5, 11 at tap 6 -> TRAIN_DONE=1, TAP_COUNT=6.
REQ-037 RX_DATA held at 00 -> TRAIN_ERR=1, TAP_COUNT=127, 127 MOVE pulses, TRAIN_BUSY=0 afterwards.
REQ-038 DELAY_LINE_OUT_OF_RANGE raised during tap 20 with RX_DATA=00 -> TRAIN_ERR=1, TAP_COUNT=20, no 21st MOVE pulse.
REQ-039 After a zero tap, a tap with 2 of 4 samples =11 -> treated as 0, sweep continues; the following tap with 3 of 4 samples =11 -> TRAIN_DONE=1.
REQ-040 RESET pulsed mid-sweep at tap 5 -> all outputs 0 in the same cycle; a subsequent TRAIN_START restarts from LOAD with TAP_COUNT=0; TRAIN_START pulsed while busy -> no effect.
